// File: rtl/sram_track_mixer_if.sv
// Codec/SRAM-side bundle of sram_track_mixer: sample strobe and controls, codec data,
// SRAM bus and status. The slave modport is the mixer; the master modport is its environment.
interface sram_track_mixer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int SEL_W  = 1
);
  logic              iSAMPLE_STB;
  logic [1:0]        iMODE;
  logic [SEL_W-1:0]  iTRACK_SEL;
  logic              iBOUNCE;
  logic              iPOS_RST;
  logic [DATA_W-1:0] iAUD_IN;
  logic [DATA_W-1:0] oAUD_OUT;
  logic              oSAMPLE_VALID;
  logic [ADDR_W-1:0] oSRAM_ADDR;
  logic [DATA_W-1:0] iSRAM_RDATA;
  logic [DATA_W-1:0] oSRAM_WDATA;
  logic              oSRAM_WE_N;
  logic              oDQ_OE;
  logic [ADDR_W-1:0] oPOS;
  logic              oBUSY;
  logic              oOVERRUN;

  modport slave (
    input  iSAMPLE_STB, iMODE, iTRACK_SEL, iBOUNCE, iPOS_RST, iAUD_IN, iSRAM_RDATA,
    output oAUD_OUT, oSAMPLE_VALID, oSRAM_ADDR, oSRAM_WDATA, oSRAM_WE_N, oDQ_OE,
           oPOS, oBUSY, oOVERRUN
  );

  modport master (
    output iSAMPLE_STB, iMODE, iTRACK_SEL, iBOUNCE, iPOS_RST, iAUD_IN, iSRAM_RDATA,
    input  oAUD_OUT, oSAMPLE_VALID, oSRAM_ADDR, oSRAM_WDATA, oSRAM_WE_N, oDQ_OE,
           oPOS, oBUSY, oOVERRUN
  );
endinterface

// File: rtl/sram_track_mixer.sv
// Multi-track record/play/mix sequencer over a single-port async SRAM, one pass per sample strobe.
// Optional macro MIX_SAT_EN: MIX result is the saturated full sum instead of the shifted average.
module sram_track_mixer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int NUM_TRACKS = 2,
  parameter int TRACK_LEN  = 128000
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  sram_track_mixer_if.slave     bus
);

  localparam int SH    = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 0;
  localparam int SEL_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
  localparam int ACC_W = DATA_W + SH;
  localparam logic [ADDR_W-1:0] TRACK_LEN_C = ADDR_W'(TRACK_LEN);
  localparam logic [ADDR_W-1:0] POS_LAST_C  = ADDR_W'(TRACK_LEN - 1);
  localparam logic [SEL_W-1:0]  TRK_LAST_C  = SEL_W'(NUM_TRACKS - 1);
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_REC  = 2'd1;
  localparam logic [1:0] MODE_PLAY = 2'd2;
  localparam logic [1:0] MODE_MIX  = 2'd3;
`ifdef MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX_C = ACC_W'($signed({1'b0, {(DATA_W-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] SAT_MIN_C = ACC_W'($signed({1'b1, {(DATA_W-1){1'b0}}}));
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    RD    = 3'd2,
    ACC   = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                    state_r, state_s;
  logic [1:0]                mode_r;
  logic [SEL_W-1:0]          sel_r;
  logic                      bounce_r;
  logic [SEL_W-1:0]          trk_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic [DATA_W-1:0]         result_r;
  logic [ADDR_W-1:0]         pos_r;
  logic                      overrun_r;
  logic [DATA_W-1:0]         aud_out_r, aud_out_s;
  logic                      valid_r, valid_s;
  logic [ADDR_W-1:0]         addr_r, addr_s;
  logic [DATA_W-1:0]         wdata_r, wdata_s;
  logic                      we_n_r, we_n_s;
  logic                      dq_oe_r, dq_oe_s;
  logic                      busy_r, busy_s;
  logic                      last_rd_s;
  logic [SEL_W-1:0]          rd_trk_s;
  logic signed [ACC_W-1:0]   rd_ext_s;
  logic [DATA_W-1:0]         result_s;
  logic [DATA_W-1:0]         result_now_s;

  function automatic logic [ADDR_W-1:0] track_addr(input logic [SEL_W-1:0] trk,
                                                   input logic [ADDR_W-1:0] pos);
    return ADDR_W'(trk) * TRACK_LEN_C + pos;
  endfunction

  assign last_rd_s = (mode_r == MODE_PLAY) || (trk_r == TRK_LAST_C);
  assign rd_ext_s  = ACC_W'($signed(bus.iSRAM_RDATA));

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = bus.iSAMPLE_STB ? LATCH : IDLE;
      LATCH: begin
        case (bus.iMODE)
          MODE_PASS: state_s = DONE;
          MODE_REC:  state_s = WR;
          MODE_PLAY: state_s = RD;
          MODE_MIX:  state_s = RD;
          default:   state_s = DONE;
        endcase
      end
      RD:      state_s = last_rd_s ? ACC : RD;
      ACC:     state_s = ((mode_r == MODE_MIX) && bounce_r) ? WR : DONE;
      WR:      state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // ACC result: PLAY passes the single read through, MIX averages or saturates
  always_comb begin
    result_s = DATA_W'(acc_r);
    if (mode_r == MODE_MIX) begin
`ifdef MIX_SAT_EN
      if (acc_r > SAT_MAX_C) begin
        result_s = DATA_W'(SAT_MAX_C);
      end else if (acc_r < SAT_MIN_C) begin
        result_s = DATA_W'(SAT_MIN_C);
      end else begin
        result_s = DATA_W'(acc_r);
      end
`else
      result_s = DATA_W'(acc_r >>> SH);
`endif
    end else begin
      result_s = DATA_W'(acc_r);
    end
  end

  // The live result: the input while latching, the fresh ACC value, else the held one
  always_comb begin
    case (state_r)
      LATCH:   result_now_s = bus.iAUD_IN;
      ACC:     result_now_s = result_s;
      default: result_now_s = result_r;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the state being entered
  always_comb begin
    we_n_s    = 1'b1;
    dq_oe_s   = 1'b0;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    valid_s   = 1'b0;
    aud_out_s = aud_out_r;
    busy_s    = (state_s != IDLE);
    if (state_r == LATCH) begin
      rd_trk_s = (bus.iMODE == MODE_PLAY) ? bus.iTRACK_SEL : '0;
    end else begin
      rd_trk_s = trk_r + SEL_W'(1);
    end
    if (state_s == RD) begin
      addr_s = track_addr(rd_trk_s, pos_r);
    end else if (state_s == WR) begin
      we_n_s  = 1'b0;
      dq_oe_s = 1'b1;
      addr_s  = track_addr((state_r == LATCH) ? bus.iTRACK_SEL : sel_r, pos_r);
      wdata_s = result_now_s;
    end else if (state_s == DONE) begin
      valid_s   = 1'b1;
      aud_out_s = result_now_s;
    end else begin
      addr_s = addr_r;
    end
  end

  // Sequencer datapath: latched controls, accumulator, position, overrun
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_r    <= MODE_PASS;
      sel_r     <= '0;
      bounce_r  <= 1'b0;
      trk_r     <= '0;
      acc_r     <= '0;
      result_r  <= '0;
      pos_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (state_r == LATCH) begin
        mode_r   <= bus.iMODE;
        sel_r    <= bus.iTRACK_SEL;
        bounce_r <= bus.iBOUNCE;
        trk_r    <= '0;
        acc_r    <= '0;
      end
      if (state_r == RD) begin
        acc_r <= acc_r + rd_ext_s;
        trk_r <= trk_r + SEL_W'(1);
      end
      if ((state_r == LATCH) || (state_r == ACC)) begin
        result_r <= result_now_s;
      end
      if ((state_r == IDLE) && bus.iPOS_RST) begin
        pos_r <= '0;
      end else if ((state_r == DONE) && (mode_r != MODE_PASS)) begin
        pos_r <= (pos_r == POS_LAST_C) ? '0 : pos_r + ADDR_W'(1);
      end
      if ((state_r != IDLE) && bus.iSAMPLE_STB) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Output registers; reset forces WE_N high immediately
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      aud_out_r <= '0;
      valid_r   <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      we_n_r    <= 1'b1;
      dq_oe_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      aud_out_r <= aud_out_s;
      valid_r   <= valid_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      we_n_r    <= we_n_s;
      dq_oe_r   <= dq_oe_s;
      busy_r    <= busy_s;
    end
  end

  assign bus.oAUD_OUT      = aud_out_r;
  assign bus.oSAMPLE_VALID = valid_r;
  assign bus.oSRAM_ADDR    = addr_r;
  assign bus.oSRAM_WDATA   = wdata_r;
  assign bus.oSRAM_WE_N    = we_n_r;
  assign bus.oDQ_OE        = dq_oe_r;
  assign bus.oPOS          = pos_r;
  assign bus.oBUSY         = busy_r;
  assign bus.oOVERRUN      = overrun_r;

endmodule

// File: tb/tb_sram_track_mixer.sv
// Randomised bench for sram_track_mixer against a sample-level reference model and an SRAM model.
module tb_sram_track_mixer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 18;
  localparam int NT     = 2;
  localparam int TL     = 40;
  localparam int SEL_W  = 1;
  localparam int DEPTH  = NT * TL;
  localparam logic [1:0] M_PASS = 2'd0;
  localparam logic [1:0] M_REC  = 2'd1;
  localparam logic [1:0] M_PLAY = 2'd2;
  localparam logic [1:0] M_MIX  = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_track_mixer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  sram_track_mixer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TRACKS(NT), .TRACK_LEN(TL)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int ref_pos;
  int n_vec = 0;
  int n_err = 0;

  assign bus.iSRAM_RDATA = (int'(bus.oSRAM_ADDR) < DEPTH) ? mem[int'(bus.oSRAM_ADDR)] : '0;

  // asynchronous SRAM: the write lands at the end of the WE_N-low cycle
  always @(posedge clk) begin
    if (!bus.oSRAM_WE_N && (int'(bus.oSRAM_ADDR) < DEPTH))
      mem[int'(bus.oSRAM_ADDR)] <= bus.oSRAM_WDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input int a, input logic [DATA_W-1:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // reference: one sample's effect, computed straight from the mode rules
  task automatic model(input logic [1:0] mode, input int sel, input logic bnc,
                       input logic [DATA_W-1:0] ain, output logic [DATA_W-1:0] out,
                       output int we, output int waddr, output logic [DATA_W-1:0] wd,
                       output int lat);
    int sum, q;
    we = 0; waddr = 0; wd = '0; out = ain; lat = 2;
    case (mode)
      M_REC: begin
        we = 1; waddr = sel * TL + ref_pos; wd = ain; lat = 3;
      end
      M_PLAY: begin
        out = ref_mem[sel * TL + ref_pos]; lat = 4;
      end
      M_MIX: begin
        sum = 0;
        for (int t = 0; t < NT; t++) sum += int'($signed(ref_mem[t * TL + ref_pos]));
`ifdef MIX_SAT_EN
        q = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
`else
        q = sum / NT;
        if ((sum % NT != 0) && (sum < 0)) q = q - 1;
`endif
        out = q[DATA_W-1:0];
        lat = NT + 3;
        if (bnc) begin
          we = 1; waddr = sel * TL + ref_pos; wd = out; lat = NT + 4;
        end
      end
      default: lat = 2;
    endcase
    if (we != 0) ref_mem[waddr] = wd;
    if (mode != M_PASS) ref_pos = (ref_pos + 1) % TL;
  endtask

  task automatic apply(input logic [1:0] mode, input int sel, input logic bnc,
                       input logic [DATA_W-1:0] ain);
    logic [DATA_W-1:0] e_out, e_wd, g_out, g_wd;
    int e_we, e_addr, e_lat, g_lat, n_we, n_val, g_addr, bad_oe;
    model(mode, sel, bnc, ain, e_out, e_we, e_addr, e_wd, e_lat);
    g_lat = 0; n_we = 0; n_val = 0; g_addr = 0; g_wd = '0; g_out = '0; bad_oe = 0;
    @(negedge clk);
    bus.iMODE = mode; bus.iTRACK_SEL = SEL_W'(sel); bus.iBOUNCE = bnc; bus.iAUD_IN = ain;
    bus.iSAMPLE_STB = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.iSAMPLE_STB = 1'b0;
      if (bus.oDQ_OE !== !bus.oSRAM_WE_N) bad_oe++;
      if (!bus.oSRAM_WE_N) begin
        n_we++; g_addr = int'(bus.oSRAM_ADDR); g_wd = bus.oSRAM_WDATA;
      end
      if (bus.oSAMPLE_VALID) begin
        n_val++;
        if (g_lat == 0) begin g_lat = c; g_out = bus.oAUD_OUT; end
      end
    end
    chk("latency", g_lat, e_lat);
    chk("aud_out", g_out, e_out);
    chk("valid_pulses", n_val, 1);
    chk("we_pulses", n_we, e_we);
    chk("dq_oe_vs_we_n", bad_oe, 0);
    if (e_we != 0) begin
      chk("wr_addr", g_addr, e_addr);
      chk("wr_data", g_wd, e_wd);
    end
    chk("pos", bus.oPOS, ref_pos);
    chk("busy_idle", bus.oBUSY, 0);
  endtask

  task automatic pos_reset();
    @(negedge clk); bus.iPOS_RST = 1'b1;
    @(negedge clk); bus.iPOS_RST = 1'b0;
    ref_pos = 0;
    chk("pos_rst", bus.oPOS, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_aud"},   bus.oAUD_OUT, 0);
    chk({tag, "_valid"}, bus.oSAMPLE_VALID, 0);
    chk({tag, "_addr"},  bus.oSRAM_ADDR, 0);
    chk({tag, "_wdata"}, bus.oSRAM_WDATA, 0);
    chk({tag, "_we_n"},  bus.oSRAM_WE_N, 1);
    chk({tag, "_oe"},    bus.oDQ_OE, 0);
    chk({tag, "_pos"},   bus.oPOS, 0);
    chk({tag, "_busy"},  bus.oBUSY, 0);
    chk({tag, "_ovr"},   bus.oOVERRUN, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] e_out, e_wd, g_out;
    int e_we, e_addr, e_lat, n_val, seen;
    bus.iSAMPLE_STB = 1'b0; bus.iMODE = M_PASS; bus.iTRACK_SEL = '0; bus.iBOUNCE = 1'b0;
    bus.iPOS_RST = 1'b0; bus.iAUD_IN = '0;
    for (int i = 0; i < DEPTH; i++) set_mem(i, DATA_W'($urandom));
    ref_pos = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    apply(M_PASS, 0, 1'b0, 16'h1234);
    repeat (5) apply(M_PLAY, $urandom_range(NT - 1, 0), 1'b0, DATA_W'($urandom));
    apply(M_REC, 1, 1'b0, 16'h0ABC);
    chk("rec_mem", mem[TL + 5], 16'h0ABC);

    pos_reset();
    set_mem(0, 16'h7FFF);
    apply(M_PLAY, 0, 1'b0, 16'h0000);

    pos_reset();
    set_mem(0, 16'h7000); set_mem(TL, 16'h7000);
    apply(M_MIX, 0, 1'b0, 16'h0000);
    set_mem(1, 16'h8000); set_mem(TL + 1, 16'h8000);
    apply(M_MIX, 0, 1'b0, 16'h0000);
    set_mem(2, 16'h0100); set_mem(TL + 2, 16'h0300);
    apply(M_MIX, 1, 1'b1, 16'h0000);
    chk("bounce_mem", mem[TL + 2], 16'h0200);

    pos_reset();
    repeat (TL) apply(M_PLAY, $urandom_range(NT - 1, 0), 1'b0, DATA_W'($urandom));
    chk("wrap_pos", bus.oPOS, 0);

    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(15, 0) == 0) pos_reset();
      apply(2'($urandom_range(3, 0)), $urandom_range(NT - 1, 0), 1'($urandom_range(1, 0)),
            DATA_W'($urandom));
    end
    chk("no_overrun_yet", bus.oOVERRUN, 0);

    // second strobe one cycle after a MIX strobe is dropped
    model(M_MIX, 0, 1'b0, 16'h0000, e_out, e_we, e_addr, e_wd, e_lat);
    @(negedge clk);
    bus.iMODE = M_MIX; bus.iBOUNCE = 1'b0; bus.iSAMPLE_STB = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.iSAMPLE_STB = 1'b0;
    n_val = 0; g_out = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus.oSAMPLE_VALID) begin n_val++; g_out = bus.oAUD_OUT; end
      @(negedge clk);
    end
    chk("ovr_flag", bus.oOVERRUN, 1);
    chk("ovr_valid_pulses", n_val, 1);
    chk("ovr_aud_out", g_out, e_out);
    chk("ovr_pos", bus.oPOS, ref_pos);

    // reset asserted mid-write aborts the write
    @(negedge clk);
    bus.iMODE = M_REC; bus.iTRACK_SEL = SEL_W'(0); bus.iAUD_IN = ~mem[ref_pos];
    bus.iSAMPLE_STB = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.iSAMPLE_STB = 1'b0;
      if (!bus.oSRAM_WE_N && seen == 0) begin
        seen = 1;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_in_wr");
      end
    end
    chk("wr_seen", seen, 1);
    ref_pos = 0;
    @(negedge clk); rst_n = 1'b1;
    apply(M_PLAY, 0, 1'b0, 16'h0000);
    apply(M_REC, 1, 1'b0, DATA_W'($urandom));

    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
